// File: rtl/seq_gen_if.sv
// seq_gen_if: request/serial-output bundle between a pattern source and seq_gen
//   master: drives start, pattern, len, repeat_n, gap, abort; observes x, x_valid, ready, busy, done
//   slave : the generator side (seq_gen)
interface seq_gen_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) ();
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] repeat_n;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             ready;
    logic             busy;
    logic             done;
    modport master (
        output start, pattern, len, repeat_n, gap, abort,
        input  x, x_valid, ready, busy, done
    );
    modport slave (
        input  start, pattern, len, repeat_n, gap, abort,
        output x, x_valid, ready, busy, done
    );
endinterface

// File: rtl/seq_gen.sv
// seq_gen: serial pattern generator, MSB-first, with repeat count and idle gap
//   clk, reset (async, active-high); bus (slave): start/pattern/len/repeat_n/gap/abort in,
//   x/x_valid (registered serial data) and ready/busy/done (decoded from state) out
module seq_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    seq_gen_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
    state_t           state, state_n;
    logic [PAT_W-1:0] pat, pat_n;
    logic [LEN_W-1:0] len_q, len_n, idx, idx_n, eff_len;
    logic [CNT_W-1:0] rep, rep_n, eff_rep;
    logic [GAP_W-1:0] gap_q, gap_n, gcnt, gcnt_n;
    logic             x_q, x_n, v_q, v_n;
    assign eff_len = (bus.len == '0 || bus.len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.len;
    assign eff_rep = (bus.repeat_n == '0) ? CNT_W'(1) : bus.repeat_n;
    always_comb begin
        state_n = state;
        pat_n   = pat;
        len_n   = len_q;
        idx_n   = idx;
        rep_n   = rep;
        gap_n   = gap_q;
        gcnt_n  = gcnt;
        if (state != IDLE && bus.abort)
            state_n = IDLE;
        else
            case (state)
                IDLE: if (bus.start && !bus.abort) begin
                    state_n = SHIFT;
                    pat_n   = bus.pattern;
                    len_n   = eff_len;
                    idx_n   = eff_len - LEN_W'(1);
                    rep_n   = eff_rep;
                    gap_n   = bus.gap;
                end
                SHIFT: if (idx != '0)
                    idx_n = idx - LEN_W'(1);
                else if (rep > CNT_W'(1)) begin
                    rep_n   = rep - CNT_W'(1);
                    idx_n   = len_q - LEN_W'(1);
                    state_n = (gap_q != '0) ? GAP : SHIFT;
                    gcnt_n  = gap_q;
                end else
                    state_n = DONE;
                GAP: if (gcnt == GAP_W'(1))
                    state_n = SHIFT;
                else
                    gcnt_n = gcnt - GAP_W'(1);
                default: state_n = IDLE;
            endcase
        // x is looked ahead from next-state values so it can be a plain register
        v_n = state_n == SHIFT;
        x_n = v_n && |(pat_n & (PAT_W'(1) << idx_n));
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            pat   <= '0;
            len_q <= '0;
            idx   <= '0;
            rep   <= '0;
            gap_q <= '0;
            gcnt  <= '0;
            x_q   <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            state <= state_n;
            pat   <= pat_n;
            len_q <= len_n;
            idx   <= idx_n;
            rep   <= rep_n;
            gap_q <= gap_n;
            gcnt  <= gcnt_n;
            x_q   <= x_n;
            v_q   <= v_n;
        end
    assign bus.x       = x_q;
    assign bus.x_valid = v_q;
    assign bus.ready   = state == IDLE;
    assign bus.busy    = state == SHIFT || state == GAP;
    assign bus.done    = state == DONE;
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed table-driven bench for seq_gen
module tb_seq_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int pass = 0;
    seq_gen_if b ();
    seq_gen dut (.clk(clk), .reset(reset), .bus(b.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [3:0]  rep;
        logic [3:0]  gap;
        int          n;
        logic [31:0] ev;
        logic [31:0] ex;
    } vec_t;
    vec_t tv[6];
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    function automatic logic [4:0] st();
        return {b.x_valid, b.x, b.busy, b.ready, b.done};
    endfunction
    task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r, input logic [3:0] g);
        b.pattern = p; b.len = l; b.repeat_n = r; b.gap = g; b.start = 1'b1;
        tick();
        b.start = 1'b0;
        b.pattern = ~p; b.len = 4'd1; b.repeat_n = 4'd15; b.gap = 4'd3;
    endtask
    initial begin
        tv[0] = '{8'hB5, 4'd8,  4'd1, 4'd0, 8, 32'b11111111,  32'b10110101};
        tv[1] = '{8'h07, 4'd3,  4'd2, 4'd2, 8, 32'b11100111,  32'b11100111};
        tv[2] = '{8'h81, 4'd0,  4'd0, 4'd0, 8, 32'b11111111,  32'b10000001};
        tv[3] = '{8'hA5, 4'd4,  4'd2, 4'd1, 9, 32'b111101111, 32'b010100101};
        tv[4] = '{8'h3C, 4'd6,  4'd1, 4'd0, 6, 32'b111111,    32'b111100};
        tv[5] = '{8'hC3, 4'd12, 4'd1, 4'd0, 8, 32'b11111111,  32'b11000011};
        b.start = 0; b.abort = 0; b.pattern = 0; b.len = 0; b.repeat_n = 0; b.gap = 0;
        tick();
        chk("reset_state", 32'(st()), 32'b00010);
        reset = 1'b0;
        tick();
        chk("idle_state", 32'(st()), 32'b00010);
        for (int t = 0; t < 6; t++) begin
            launch(tv[t].pat, tv[t].len, tv[t].rep, tv[t].gap);
            for (int i = 0; i < tv[t].n; i++) begin
                chk($sformatf("vec%0d_cyc%0d", t, i + 1), 32'(st()),
                    32'({tv[t].ev[tv[t].n-1-i], tv[t].ex[tv[t].n-1-i], 3'b100}));
                tick();
            end
            chk($sformatf("vec%0d_done", t), 32'(st()), 32'b00001);
            tick();
            chk($sformatf("vec%0d_ready", t), 32'(st()), 32'b00010);
        end
        // async reset mid-shift: outputs must drop before any clock edge
        launch(8'hFF, 4'd8, 4'd1, 4'd0);
        tick();
        tick();
        chk("ff_shifting", 32'(st()), 32'b11100);
        #3 reset = 1'b1;
        #1 chk("async_reset", 32'(st()), 32'b00010);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("post_reset%0d", i), 32'(st()), 32'b00010);
            tick();
        end
        // back-to-back repeats, ignored busy start, abort after 6 bits
        launch(8'hA5, 4'd4, 4'd3, 4'd0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("b2b_cyc%0d", i + 1), 32'(st()), 32'({1'b1, 1'(i % 2), 3'b100}));
            b.start = (i == 1);
            if (i == 5) b.abort = 1'b1;
            tick();
        end
        b.start = 1'b0;
        b.abort = 1'b0;
        chk("abort_idle", 32'(st()), 32'b00010);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("abort_quiet%0d", i), 32'(st()), 32'b00010);
        end
        // abort together with start in IDLE blocks acceptance
        b.start = 1'b1; b.abort = 1'b1; b.pattern = 8'hFF; b.len = 4'd8; b.repeat_n = 4'd1;
        tick();
        b.start = 1'b0; b.abort = 1'b0;
        chk("abort_start", 32'(st()), 32'b00010);
        // max repeat count and gap
        launch(8'h01, 4'd1, 4'd15, 4'd15);
        begin
            int nv = 0;
            for (int c = 0; c < 225; c++) begin
                logic ev;
                ev = (c % 16) == 0;
                nv += int'(b.x_valid);
                chk($sformatf("max_cyc%0d", c + 1), 32'(st()), 32'({ev, ev, 3'b100}));
                tick();
            end
            chk("max_nvalid", nv, 15);
        end
        chk("max_done", 32'(st()), 32'b00001);
        tick();
        chk("max_ready", 32'(st()), 32'b00010);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Serial bit-pattern generator: the transmit side of the serial sequence-detection path.
- Accepts a pattern word through a start/ready handshake and shifts it out MSB-first on a one-bit serial line with a qualifying valid.
- Can repeat the pattern a programmable number of times with a programmable idle gap between repetitions.
- Sits upstream of the serial detectors and drives their x input in system and loopback tests.

Parameters:
- PAT_W, 8: maximum pattern width in bits.
- LEN_W, 4: width of the len port; must satisfy 2^LEN_W > PAT_W.
- CNT_W, 4: width of the repeat-count port.
- GAP_W, 4: width of the inter-repetition gap port.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only on a clock edge where start && ready.
- pattern  in  PAT_W  bits to send; pattern[len-1] is sent first, pattern[0] last.
- len  in  LEN_W  number of bits per repetition; 0 or >PAT_W is treated as PAT_W.
- repeat_n  in  CNT_W  number of repetitions; 0 is treated as 1.
- gap  in  GAP_W  idle cycles between repetitions; 0 means back-to-back.
- abort  in  1  synchronous cancel of the current transfer.
- x  out  1  serial data, registered.
- x_valid  out  1  high while x carries a pattern bit, registered.
- ready  out  1  high only in IDLE.
- busy  out  1  high in SHIFT and GAP.
- done  out  1  one-cycle pulse after the final bit of the final repetition.

Behaviour:
- Reset (asynchronous, active-high, any time including mid-transfer):
  - state=IDLE; x=0, x_valid=0, ready=1, busy=0, done=0.
  - Shift register and all counters cleared.
  - Transfer is lost; no done is produced.
- States: IDLE, SHIFT, GAP, DONE. All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- IDLE:
  - On an edge with start=1, ready=1 and abort=0: capture pattern, effective len, effective repeat_n and gap; go to SHIFT.
  - The first bit appears on x in the cycle following the accepting edge (latency 1).
- SHIFT:
  - x_valid=1 for exactly len consecutive cycles per repetition.
  - x = captured pattern[len-1], then pattern[len-2], ..., down to pattern[0].
  - Each repetition reloads from the captured copy.
  - After the last bit: if repetitions remain and gap>0, go to GAP; if repetitions remain and gap=0, start the next repetition on the next cycle with no valid bubble; otherwise go to DONE.
- GAP:
  - x=0, x_valid=0 for exactly gap cycles, then SHIFT with a fresh reload.
- DONE:
  - Lasts one cycle: done=1, ready=0, busy=0, x_valid=0, x=0.
  - Always returns to IDLE on the next cycle.
- start while not ready: ignored, with no queuing; start must be reasserted once ready=1.
- Input changes during a transfer: changes to pattern, len, repeat_n and gap after acceptance have no effect.
- abort:
  - Priority below reset and above everything else.
  - Sampled high in SHIFT, GAP or DONE: next state is IDLE, so x_valid=0, ready=1 and done=0 in the following cycle.
  - A done pulse already showing in DONE is not extended.
  - abort together with start in IDLE: start is ignored.
- Counters:
  - Bit index counts len-1 down to 0.
  - Repetition counter is CNT_W bits, loaded with the effective repeat_n and decremented at the end of each repetition.
  - Gap counter is GAP_W bits.
  - No counter wraps: the maximum values repeat_n=2^CNT_W-1 and gap=2^GAP_W-1 must be honoured exactly.
- x is 0 whenever x_valid=0.

Test Plan:
- Reset:
  - Stimulus: assert reset mid-SHIFT of pattern 8'hFF, then release.
  - Required: x, x_valid, busy and done go 0 immediately and ready goes 1 without waiting for clk; after release, no residual bits are sent.
- Single shot:
  - Stimulus: pattern=8'hB5, len=8, repeat_n=1, gap=0, start accepted at edge 0.
  - Required: x=1,0,1,1,0,1,0,1 with x_valid=1 on cycles 1-8; done=1 on cycle 9; ready=1 on cycle 10.
- Repeat with gap:
  - Stimulus: pattern=8'h07, len=3, repeat_n=2, gap=2.
  - Required: x_valid pattern 1,1,1,0,0,1,1,1 with x=1 on every valid cycle; done on the cycle after the 8th.
- Clamping:
  - Stimulus: len=0, repeat_n=0, pattern=8'h81.
  - Required: 8 bits 1,0,0,0,0,0,0,1 sent once, then done.
- Back-to-back, busy start and abort:
  - Stimulus: pattern=8'hA5, len=4, repeat_n=3, gap=0; pulse start during SHIFT; assert abort after 6 valid bits.
  - Required: bits 0,1,0,1,0,1 appear with no bubble and the extra start has no effect; x_valid=0 and ready=1 on the next cycle; done never asserts.
- Max counts:
  - Stimulus: pattern=8'h01, len=1, repeat_n=15, gap=15.
  - Required: exactly 15 valid bits each =1, separated by exactly 15 idle cycles; a single done.
